// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder and the control decoder.
//
// Holds the operation ID enum (op_t, carried on in_op), the word-format and
// write-FSM state enums, and every opcode / funct constant of the ISA.
// No ports: package only.

package instr_encoder_pkg;

    // Operation IDs as presented on in_op. Values above OpLwc1 are illegal.
    typedef enum logic [5:0] {
        OpAdd   = 6'd0,
        OpAnd   = 6'd1,
        OpNor   = 6'd2,
        OpOr    = 6'd3,
        OpSlt   = 6'd4,
        OpSltu  = 6'd5,
        OpSll   = 6'd6,
        OpSrl   = 6'd7,
        OpSra   = 6'd8,
        OpSub   = 6'd9,
        OpSubu  = 6'd10,
        OpJr    = 6'd11,
        OpLwn   = 6'd12,
        OpSwn   = 6'd13,
        OpMult  = 6'd14,
        OpMultu = 6'd15,
        OpDiv   = 6'd16,
        OpDivu  = 6'd17,
        OpMfhi  = 6'd18,
        OpMflo  = 6'd19,
        OpAddi  = 6'd20,
        OpAddiu = 6'd21,
        OpAndi  = 6'd22,
        OpBeq   = 6'd23,
        OpBne   = 6'd24,
        OpLbu   = 6'd25,
        OpLui   = 6'd26,
        OpLw    = 6'd27,
        OpOri   = 6'd28,
        OpSb    = 6'd29,
        OpSw    = 6'd30,
        OpJ     = 6'd31,
        OpJal   = 6'd32,
        OpLwc1  = 6'd33
    } op_t;

    typedef enum logic [1:0] {
        FmtR,
        FmtI,
        FmtJ
    } fmt_e;

    typedef enum logic [0:0] {
        StIdle,
        StWrite
    } wr_state_e;

    // R-type primary opcode
    localparam logic [5:0] OPC_RTYPE   = 6'b000001;

    // R-type funct field values
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_AND   = 6'b010100;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU  = 6'b101011;
    localparam logic [5:0] FUNCT_SLL   = 6'b000000;
    localparam logic [5:0] FUNCT_SRL   = 6'b000010;
    localparam logic [5:0] FUNCT_SRA   = 6'b000011;
    localparam logic [5:0] FUNCT_SUB   = 6'b100100;
    localparam logic [5:0] FUNCT_SUBU  = 6'b100010;
    localparam logic [5:0] FUNCT_JR    = 6'b001000;
    localparam logic [5:0] FUNCT_LWN   = 6'b100001;
    localparam logic [5:0] FUNCT_SWN   = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

    // I-type opcodes
    localparam logic [5:0] OPC_ADDI    = 6'b001001;
    localparam logic [5:0] OPC_ADDIU   = 6'b001000;
    localparam logic [5:0] OPC_ANDI    = 6'b001100;
    localparam logic [5:0] OPC_BEQ     = 6'b000101;
    localparam logic [5:0] OPC_BNE     = 6'b000100;
    localparam logic [5:0] OPC_LBU     = 6'b100010;
    localparam logic [5:0] OPC_LUI     = 6'b001111;
    localparam logic [5:0] OPC_LW      = 6'b010010;
    localparam logic [5:0] OPC_ORI     = 6'b001110;
    localparam logic [5:0] OPC_SB      = 6'b101000;
    localparam logic [5:0] OPC_SW      = 6'b101011;
    localparam logic [5:0] OPC_LWC1    = 6'b110001;

    // J-type opcodes
    localparam logic [5:0] OPC_J       = 6'b000010;
    localparam logic [5:0] OPC_JAL     = 6'b000011;

endpackage

// File: rtl/enc_fifo.sv
// Encoded-word FIFO for the instruction encoder.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset (empties the FIFO)
//   push_i   write wdata_i (ignored when full)
//   wdata_i  word to write
//   pop_i    drop the head entry (ignored when empty)
//   rdata_o  head entry, valid while !empty_o
//   full_o   no free entry
//   empty_o  no stored entry
//   count_o  occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.

module enc_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        wdata_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        rdata_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == (PtrW + 1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (PtrW + 1)'(1);
                2'b01:   cnt_q <= cnt_q - (PtrW + 1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone says what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: turns operation requests into 32-bit machine words,
// buffers them, and writes them sequentially into instruction memory.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   start, base_addr   load the write address and clear count (idle + empty only)
//   in_valid/in_ready  request handshake; in_ready = FIFO not full (0 in reset)
//   in_op              operation ID (op_t)
//   in_rs/rt/rd/shamt  register and shift fields
//   in_imm, in_target  immediate and jump-target fields
//   imem_we/addr/wdata write request, held stable until imem_ack
//   imem_ack           memory accepted the current write
//   err_illegal        sticky: an illegal or disabled op was accepted
//   count              words committed since last start (saturating)
//
// Build option: define INSTR_ENC_FLOAT_EN to encode LWC1 (I-type, 110001);
// otherwise LWC1 is treated as an illegal op.

module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [15:0] in_imm,
    input  logic [25:0] in_target,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    input  logic        imem_ack,
    output logic        err_illegal,
    output logic [15:0] count
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    wr_state_e       state_q, state_d;
    logic [31:0]     addr_q;
    logic [15:0]     count_q;
    logic            err_q;

    fmt_e            enc_fmt;
    logic [5:0]      enc_code;
    logic            enc_legal;
    logic [31:0]     enc_word;

    logic            accept;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CntW-1:0] fifo_count;

    // Opcode / funct lookup. enc_code is the funct for R-type and the
    // primary opcode for I- and J-type.
    always_comb begin
        enc_fmt   = FmtR;
        enc_code  = '0;
        enc_legal = 1'b1;
        case (in_op)
            OpAdd:   enc_code = FUNCT_ADD;
            OpAnd:   enc_code = FUNCT_AND;
            OpNor:   enc_code = FUNCT_NOR;
            OpOr:    enc_code = FUNCT_OR;
            OpSlt:   enc_code = FUNCT_SLT;
            OpSltu:  enc_code = FUNCT_SLTU;
            OpSll:   enc_code = FUNCT_SLL;
            OpSrl:   enc_code = FUNCT_SRL;
            OpSra:   enc_code = FUNCT_SRA;
            OpSub:   enc_code = FUNCT_SUB;
            OpSubu:  enc_code = FUNCT_SUBU;
            OpJr:    enc_code = FUNCT_JR;
            OpLwn:   enc_code = FUNCT_LWN;
            OpSwn:   enc_code = FUNCT_SWN;
            OpMult:  enc_code = FUNCT_MULT;
            OpMultu: enc_code = FUNCT_MULTU;
            OpDiv:   enc_code = FUNCT_DIV;
            OpDivu:  enc_code = FUNCT_DIVU;
            OpMfhi:  enc_code = FUNCT_MFHI;
            OpMflo:  enc_code = FUNCT_MFLO;
            OpAddi:  begin enc_fmt = FmtI; enc_code = OPC_ADDI;  end
            OpAddiu: begin enc_fmt = FmtI; enc_code = OPC_ADDIU; end
            OpAndi:  begin enc_fmt = FmtI; enc_code = OPC_ANDI;  end
            OpBeq:   begin enc_fmt = FmtI; enc_code = OPC_BEQ;   end
            OpBne:   begin enc_fmt = FmtI; enc_code = OPC_BNE;   end
            OpLbu:   begin enc_fmt = FmtI; enc_code = OPC_LBU;   end
            OpLui:   begin enc_fmt = FmtI; enc_code = OPC_LUI;   end
            OpLw:    begin enc_fmt = FmtI; enc_code = OPC_LW;    end
            OpOri:   begin enc_fmt = FmtI; enc_code = OPC_ORI;   end
            OpSb:    begin enc_fmt = FmtI; enc_code = OPC_SB;    end
            OpSw:    begin enc_fmt = FmtI; enc_code = OPC_SW;    end
            OpJ:     begin enc_fmt = FmtJ; enc_code = OPC_J;     end
            OpJal:   begin enc_fmt = FmtJ; enc_code = OPC_JAL;   end
            OpLwc1: begin
`ifdef INSTR_ENC_FLOAT_EN
                enc_fmt  = FmtI;
                enc_code = OPC_LWC1;
`else
                enc_legal = 1'b0;
`endif
            end
            default: enc_legal = 1'b0;
        endcase
    end

    // Word assembly; lui has no source register, so rs is forced to zero.
    always_comb begin
        case (enc_fmt)
            FmtI:    enc_word = {enc_code, (in_op == OpLui) ? 5'd0 : in_rs, in_rt, in_imm};
            FmtJ:    enc_word = {enc_code, in_target};
            default: enc_word = {OPC_RTYPE, in_rs, in_rt, in_rd, in_shamt, enc_code};
        endcase
    end

    assign in_ready = !fifo_full && !rst;
    assign accept   = in_valid && in_ready;
    assign push     = accept && enc_legal;

    enc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_enc_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push),
        .wdata_i (enc_word),
        .pop_i   (pop),
        .rdata_o (imem_wdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Write FSM. The FIFO head feeds imem_wdata directly, so it stays stable
    // until the pop on imem_ack.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (imem_ack) begin
                    pop = 1'b1;
                    // Last word leaving with nothing arriving behind it.
                    if ((fifo_count == CntW'(1)) && !push) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                addr_q <= addr_q + 32'(ADDR_STEP);
                if (count_q != 16'hFFFF) begin
                    count_q <= count_q + 16'd1;
                end
            end else if (start && (state_q == StIdle) && fifo_empty) begin
                addr_q  <= base_addr;
                count_q <= '0;
            end
            if (accept && !enc_legal) begin
                err_q <= 1'b1;
            end
        end
    end

    assign imem_we     = (state_q == StWrite) && !rst;
    assign imem_addr   = addr_q;
    assign count       = count_q;
    assign err_illegal = err_q;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: encoded-word buffer entries, power of two, minimum 2.
REQ-002 Parameter ADDR_STEP, default 4: byte increment of imem_addr per committed word.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port start, input, 1: pulse that loads base_addr into the address counter and clears count.
REQ-006 Port base_addr, input, 32: first instruction-memory byte address.
REQ-007 Port in_valid / in_ready, input / output, 1 each: request handshake.
REQ-008 Port in_op, input, 6: operation ID; the op_t enum in the package.
REQ-009 Ports in_rs, in_rt, in_rd, in_shamt, inputs, 5 each: instruction fields.
REQ-010 Port in_imm, input, 16: immediate field.
REQ-011 Port in_target, input, 26: jump target field.
REQ-012 Ports imem_we, output, 1; imem_addr, output, 32; imem_wdata, output, 32: write request to instruction memory.
REQ-013 Port imem_ack, input, 1: memory has accepted the current write.
REQ-014 Port err_illegal, output, 1: sticky flag for an illegal or disabled op.
REQ-015 Port count, output, 16: number of words committed since the last start.

Function
REQ-016 The block SHALL accept a request when in_valid and in_ready are both high on a clock edge; in_ready SHALL equal !fifo_full.
REQ-017 R-type words SHALL be {6'b000001, rs, rt, rd, shamt, funct}.
REQ-018 R-type funct values SHALL be: add 100000, and 010100, nor 100111, or 100101, slt 101010, sltu 101011, sll 000000, srl 000010, sra 000011, sub 100100, subu 100010, jr 001000, lwn 100001, swn 010011, mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mflo 010010.
REQ-019 I-type words SHALL be {opcode, rs, rt, imm}, with opcodes: addi 001001, addiu 001000, andi 001100, beq 000101, bne 000100, lbu 100010, lui 001111, lw 010010, ori 001110, sb 101000, sw 101011.
REQ-020 For lui, the rs field SHALL be forced to 0.
REQ-021 J-type words SHALL be {opcode, target}, with j 000010 and jal 000011.
REQ-022 An accepted legal op SHALL push its encoded word into the FIFO in the same cycle.
REQ-023 An accepted illegal op SHALL be consumed but not pushed, and SHALL set err_illegal.
REQ-024 The write FSM SHALL have states IDLE and WRITE.
REQ-025 IDLE SHALL go to WRITE when the FIFO is non-empty; imem_we=1 and imem_addr/imem_wdata SHALL hold stable in WRITE until imem_ack.
REQ-026 On an imem_ack edge, the FSM SHALL pop the FIFO, add ADDR_STEP to the address, and increment count.
REQ-027 After the ack, the FSM SHALL stay in WRITE if more words remain in the FIFO, otherwise go to IDLE.
REQ-028 Latency: a word accepted at edge N SHALL be driven on imem_wdata from cycle N+1 at the earliest.
REQ-029 A simultaneous push and pop SHALL leave the occupancy unchanged.
REQ-030 The address SHALL wrap modulo 2^32; count SHALL saturate at 0xFFFF.
REQ-031 start SHALL take effect only in IDLE with the FIFO empty; otherwise it SHALL be ignored.
REQ-032 imem_ack outside WRITE SHALL be ignored.

Reset
REQ-033 rst SHALL put the FSM in IDLE, empty the FIFO, and zero the address, count and err_illegal.
REQ-034 While rst is asserted, imem_we SHALL be 0 and in_ready SHALL be 0.
REQ-035 Reset during WRITE SHALL abandon the in-flight word without a later replay.

Configuration
REQ-036 With INSTR_ENC_FLOAT_EN defined, op LWC1 SHALL encode as I-type with opcode 110001.
REQ-037 Without INSTR_ENC_FLOAT_EN, LWC1 SHALL be treated as illegal per REQ-023.

Structure
REQ-038 A shared package SHALL hold the op_t enum and all opcode and funct constants, for use by both this block and the control decoder.
REQ-039 The FIFO SHALL be a sub-module named enc_fifo.

Verification
REQ-040 add rs=1, rt=2, rd=3 with base 0x0 -> imem_wdata 0x04221820 at address 0x0; count 1.
REQ-041 sw rs=29, rt=5, imm=0x0008 -> 0xAFA50008; j target=0x10 -> 0x08000010 at the next address, base+4.
REQ-042 Hold imem_ack low for 6 pushes at depth 4 -> in_ready low after 4 accepts; no word lost or reordered after ack resumes.
REQ-043 Accept in_op=LWC1 with the macro off -> err_illegal=1, nothing written; with the macro on -> opcode 110001.
REQ-044 base_addr 0xFFFFFFFC with two words -> second word written at address 0x00000000.
REQ-045 Assert rst during WRITE -> next cycle imem_we=0, count=0, FIFO empty.
